wide_mult_axi_legup_div_sequential: RTL and testbench

Iterative radix-2 restoring divider. It is the inverse-operation companion to the pipelined multiplier in the same HLS-generated datapath and shares its `clock`/`clken` stall semantics and its `representation` parameter. It accepts one numerator/denominator pair per `start`, takes one cycle per quotient bit, and returns quotient, remainder and a divide-by-zero flag with a one-cycle `done` pulse. It trades latency for area where a fully pipelined divider is too large.

---
 rtl/wide_mult_axi_legup_div_sequential_pkg.sv | 18 +
 rtl/wide_mult_axi_legup_div_sequential_if.sv | 24 ++
 rtl/wide_mult_axi_legup_div_step.sv | 22 ++
 rtl/wide_mult_axi_legup_div_sequential.sv | 136 +++++++++++++
 tb/tb_wide_mult_axi_legup_div_sequential.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wide_mult_axi_legup_div_sequential_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state enum, representation names and counter sizing.
package wide_mult_axi_legup_div_sequential_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam string REP_UNSIGNED = "UNSIGNED";
  localparam string REP_SIGNED   = "SIGNED";

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/wide_mult_axi_legup_div_sequential_if.sv
// Request/result bundle of the divider: start, numer, denom in;
// busy, done, quotient, remain, div_by_zero out. master = requester.
interface wide_mult_axi_legup_div_sequential_if #(
  parameter int width = 32
);
  logic             start;
  logic [width-1:0] numer;
  logic [width-1:0] denom;
  logic             busy;
  logic             done;
  logic [width-1:0] quotient;
  logic [width-1:0] remain;
  logic             div_by_zero;

  modport master (
    output start, numer, denom,
    input  busy, done, quotient, remain, div_by_zero
  );

  modport slave (
    input  start, numer, denom,
    output busy, done, quotient, remain, div_by_zero
  );
endinterface

// File: rtl/wide_mult_axi_legup_div_step.sv
// One combinational restoring-division step.
// Ports: rem_in, dvsr, nbit in; rem_out, qbit out.
module wide_mult_axi_legup_div_step #(
  parameter int width = 32
) (
  input  logic [width-1:0] rem_in,
  input  logic [width-1:0] dvsr,
  input  logic             nbit,
  output logic [width-1:0] rem_out,
  output logic             qbit
);
  logic [width:0] shifted;
  logic [width:0] diff;

  assign shifted = {rem_in, nbit};
  assign diff    = shifted - {1'b0, dvsr};

  // A set rem_in MSB means shifted >= 2^width > dvsr, where the
  // width+1 bit difference sign is not meaningful.
  assign qbit    = rem_in[width-1] | ~diff[width];
  assign rem_out = qbit ? diff[width-1:0] : shifted[width-1:0];
endmodule

// File: rtl/wide_mult_axi_legup_div_sequential.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports: clock, aclr_n, clken, bus (slave: start/operands in, results out).
module wide_mult_axi_legup_div_sequential
  import wide_mult_axi_legup_div_sequential_pkg::*;
#(
  parameter int    width          = 32,
  parameter string representation = REP_UNSIGNED
) (
  input logic clock,
  input logic aclr_n,
  input logic clken,
  wide_mult_axi_legup_div_sequential_if.slave bus
);
  localparam bit IS_SIGNED = (representation == REP_SIGNED);
  localparam int CW        = cnt_width(width);
  localparam logic [CW-1:0] CNT_INIT = CW'(width);

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [width-1:0] num_q;
  logic [width-1:0] den_q;
  logic [width-1:0] rem_q;
  logic [width-1:0] raw_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             zero_q;

  logic             busy_q;
  logic             done_q;
  logic [width-1:0] quo_o;
  logic [width-1:0] rem_o;
  logic             dbz_o;

  logic [width-1:0] num_mag;
  logic [width-1:0] den_mag;
  logic [width-1:0] rem_nx;
  logic             qbit;
  logic             last;
  logic             n_neg;
  logic             d_neg;

  assign n_neg   = IS_SIGNED & bus.numer[width-1];
  assign d_neg   = IS_SIGNED & bus.denom[width-1];
  assign num_mag = n_neg ? -bus.numer : bus.numer;
  assign den_mag = d_neg ? -bus.denom : bus.denom;
  assign last    = (cnt_q == CW'(1));

  wide_mult_axi_legup_div_step #(
    .width (width)
  ) u_step (
    .rem_in  (rem_q),
    .dvsr    (den_q),
    .nbit    (num_q[width-1]),
    .rem_out (rem_nx),
    .qbit    (qbit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
    end else if (clken) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      raw_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_o   <= '0;
      rem_o   <= '0;
      dbz_o   <= 1'b0;
    end else if (clken) begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            num_q   <= num_mag;
            den_q   <= den_mag;
            raw_q   <= bus.numer;
            neg_r_q <= n_neg;
            neg_q_q <= n_neg ^ d_neg;
            zero_q  <= (bus.denom == '0);
            rem_q   <= '0;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          // num_q shifts the dividend out and the quotient in.
          rem_q <= rem_nx;
          num_q <= {num_q[width-2:0], qbit};
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          dbz_o  <= zero_q;
          if (zero_q) begin
            quo_o <= '1;
            rem_o <= raw_q;
          end else begin
            quo_o <= neg_q_q ? -num_q : num_q;
            rem_o <= neg_r_q ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_o;
  assign bus.remain      = rem_o;
  assign bus.div_by_zero = dbz_o;
endmodule

// File: tb/tb_wide_mult_axi_legup_div_sequential.sv
// Scoreboard bench for the sequential divider, one unsigned and one
// signed instance sharing clock, reset and clock enable.
module tb_wide_mult_axi_legup_div_sequential;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          due;
  } exp_t;

  logic clock  = 1'b0;
  logic aclr_n = 1'b0;
  logic clken  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;

  exp_t q_u[$];
  exp_t q_s[$];

  always #5 clock = ~clock;
  always @(posedge clock) ecnt <= ecnt + 1;

  wide_mult_axi_legup_div_sequential_if #(.width(32)) u_if();
  wide_mult_axi_legup_div_sequential_if #(.width(32)) s_if();

  wide_mult_axi_legup_div_sequential #(
    .width(32), .representation("UNSIGNED")
  ) u_dut (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .bus(u_if)
  );

  wide_mult_axi_legup_div_sequential #(
    .width(32), .representation("SIGNED")
  ) s_dut (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .bus(s_if)
  );

  function automatic exp_t model(input bit sgn, input logic [31:0] n,
                                 input logic [31:0] d);
    exp_t   e;
    longint a;
    longint b;
    e.due = 0;
    e.z   = 1'b0;
    if (d == 0) begin
      e.q = '1;
      e.r = n;
      e.z = 1'b1;
    end else if (!sgn) begin
      e.q = n / d;
      e.r = n % d;
    end else begin
      a   = longint'($signed(n));
      b   = longint'($signed(d));
      e.q = 32'(a / b);
      e.r = 32'(a % b);
    end
    return e;
  endfunction

  // Unsigned result monitor
  logic u_prev = 1'b0;
  always @(posedge clock) begin
    exp_t e;
    logic ce;
    ce = clken;
    #1;
    if (!aclr_n) begin
      u_prev = 1'b0;
    end else if (ce) begin
      if (u_prev) begin
        checks++;
        if (u_if.done !== 1'b0) begin
          errors++;
          $display("FAIL u_done_width done=%b required 0", u_if.done);
        end
      end
      if (u_if.done === 1'b1) begin
        checks++;
        if (q_u.size() == 0) begin
          errors++;
          $display("FAIL u_unexpected_done at edge %0d", ecnt);
        end else begin
          e = q_u.pop_front();
          if ({u_if.quotient, u_if.remain, u_if.div_by_zero}
              !== {e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL u_result got q=%h r=%h z=%b required q=%h r=%h z=%b",
                     u_if.quotient, u_if.remain, u_if.div_by_zero,
                     e.q, e.r, e.z);
          end
          checks++;
          if (ecnt !== e.due) begin
            errors++;
            $display("FAIL u_latency done edge %0d required %0d", ecnt, e.due);
          end
        end
      end
      u_prev = u_if.done;
    end
  end

  // Signed result monitor
  logic s_prev = 1'b0;
  always @(posedge clock) begin
    exp_t e;
    logic ce;
    ce = clken;
    #1;
    if (!aclr_n) begin
      s_prev = 1'b0;
    end else if (ce) begin
      if (s_prev) begin
        checks++;
        if (s_if.done !== 1'b0) begin
          errors++;
          $display("FAIL s_done_width done=%b required 0", s_if.done);
        end
      end
      if (s_if.done === 1'b1) begin
        checks++;
        if (q_s.size() == 0) begin
          errors++;
          $display("FAIL s_unexpected_done at edge %0d", ecnt);
        end else begin
          e = q_s.pop_front();
          if ({s_if.quotient, s_if.remain, s_if.div_by_zero}
              !== {e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL s_result got q=%h r=%h z=%b required q=%h r=%h z=%b",
                     s_if.quotient, s_if.remain, s_if.div_by_zero,
                     e.q, e.r, e.z);
          end
          checks++;
          if (ecnt !== e.due) begin
            errors++;
            $display("FAIL s_latency done edge %0d required %0d", ecnt, e.due);
          end
        end
      end
      s_prev = s_if.done;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic start_op(input bit sgn, input logic [31:0] n,
                          input logic [31:0] d, input logic [31:0] eq,
                          input logic [31:0] er, input bit ez,
                          input int extra);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.z   = ez;
    e.due = ecnt + 1 + 33 + extra;
    if (sgn) begin
      s_if.start = 1'b1;
      s_if.numer = n;
      s_if.denom = d;
      q_s.push_back(e);
    end else begin
      u_if.start = 1'b1;
      u_if.numer = n;
      u_if.denom = d;
      q_u.push_back(e);
    end
    tick();
    u_if.start = 1'b0;
    s_if.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q_u.size() != 0 || q_s.size() != 0 ||
            u_if.busy || s_if.busy) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout pending u=%0d s=%0d required 0",
               q_u.size(), q_s.size());
      q_u.delete();
      q_s.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({u_if.busy, u_if.done, u_if.quotient, u_if.remain,
         u_if.div_by_zero} !== '0) begin
      errors++;
      $display("FAIL u_reset_state busy=%b done=%b q=%h r=%h z=%b required all 0",
               u_if.busy, u_if.done, u_if.quotient, u_if.remain,
               u_if.div_by_zero);
    end
    checks++;
    if ({s_if.busy, s_if.done, s_if.quotient, s_if.remain,
         s_if.div_by_zero} !== '0) begin
      errors++;
      $display("FAIL s_reset_state busy=%b done=%b q=%h r=%h z=%b required all 0",
               s_if.busy, s_if.done, s_if.quotient, s_if.remain,
               s_if.div_by_zero);
    end
    @(negedge clock);
    aclr_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_basic();
    start_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);
    wait_idle();
    start_op(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0);
    wait_idle();
    start_op(0, 32'd7, 32'd100, 32'd0, 32'd7, 0, 0);
    wait_idle();
    start_op(0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd1, 0, 0);
    wait_idle();
  endtask

  task automatic test_signed_rules();
    start_op(1, -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0);
    wait_idle();
    start_op(1, 32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 0, 0);
    wait_idle();
    start_op(1, -32'sd100, -32'sd7, 32'd14, 32'hFFFFFFFE, 0, 0);
    wait_idle();
  endtask

  task automatic test_div_zero();
    start_op(0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1, 0);
    start_op(1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1, 0);
    wait_idle();
    start_op(1, 32'h80000005, 32'd0, 32'hFFFFFFFF, 32'h80000005, 1, 0);
    wait_idle();
  endtask

  task automatic test_overflow();
    start_op(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 0);
    wait_idle();
  endtask

  task automatic test_stall();
    start_op(0, 32'd1000, 32'd10, 32'd100, 32'd0, 0, 5);
    repeat (10) tick();
    u_if.start = 1'b1;
    u_if.numer = 32'd5;
    u_if.denom = 32'd1;
    tick();
    u_if.start = 1'b0;
    clken = 1'b0;
    repeat (5) tick();
    clken = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    start_op(0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'd0, 0, 0);
    repeat (9) tick();
    aclr_n = 1'b0;
    #1;
    checks++;
    if ({u_if.busy, u_if.done, u_if.quotient, u_if.remain,
         u_if.div_by_zero} !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b q=%h r=%h z=%b required all 0",
               u_if.busy, u_if.done, u_if.quotient, u_if.remain,
               u_if.div_by_zero);
    end
    q_u.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    aclr_n = 1'b1;
    repeat (40) tick();
    start_op(0, 32'd255, 32'd16, 32'd15, 32'd15, 0, 0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    exp_t m;
    int   n = 0;
    m = model(0, 32'd1234567, 32'd89);
    start_op(0, 32'd1234567, 32'd89, m.q, m.r, m.z, 0);
    while (u_if.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL b2b_wait done=%b required 1", u_if.done);
    end
    m = model(0, 32'hDEADBEEF, 32'd1000);
    start_op(0, 32'hDEADBEEF, 32'd1000, m.q, m.r, m.z, 0);
    wait_idle();
  endtask

  task automatic test_random();
    exp_t        m;
    logic [31:0] n;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      n = $urandom;
      d = $urandom >> $urandom_range(0, 31);
      if (i == 3) d = 32'd0;
      m = model(0, n, d);
      start_op(0, n, d, m.q, m.r, m.z, 0);
      m = model(1, n, d);
      start_op(1, n, d, m.q, m.r, m.z, 0);
      wait_idle();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout reached at edge %0d", ecnt);
    $fatal(1, "timeout");
  end

  initial begin
    u_if.start = 1'b0;
    u_if.numer = '0;
    u_if.denom = '0;
    s_if.start = 1'b0;
    s_if.numer = '0;
    s_if.denom = '0;
    test_reset();
    test_unsigned_basic();
    test_signed_rules();
    test_div_zero();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
